// File: rtl/rx_word_aligner_pkg.sv
// Shared definitions for the RX word aligner slice: state encoding,
// word geometry and the default training sync word.
package rx_align_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned SLIP_W = 3;
  localparam int unsigned CAT_W  = 2 * WORD_W;

  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  // Next rotation in the hunt; wraps 7 -> 0 by natural overflow.
  function automatic logic [SLIP_W-1:0] next_slip(input logic [SLIP_W-1:0] slip);
    return slip + SLIP_W'(1);
  endfunction

endpackage

// File: rtl/rx_word_aligner_if.sv
// Lane-side bundle for rx_word_aligner: bit-aligned input word stream plus
// control, and the rotated output word with lock/slip/error status.
// Signal names match the original port list so wiring maps one to one.
interface rx_word_aligner_if;
  import rx_align_pkg::*;

  logic              algn_done_i;
  logic              restart_i;
  logic              valid_i;
  logic [WORD_W-1:0] data_i;
  logic [WORD_W-1:0] data_o;
  logic              valid_o;
  logic              lock_o;
  logic [SLIP_W-1:0] slip_o;
  logic              err_o;

  // Upstream side: bit-alignment stage and control feeding the aligner.
  modport master (
    output algn_done_i, restart_i, valid_i, data_i,
    input  data_o, valid_o, lock_o, slip_o, err_o
  );

  // Aligner side.
  modport slave (
    input  algn_done_i, restart_i, valid_i, data_i,
    output data_o, valid_o, lock_o, slip_o, err_o
  );

endinterface

// File: rtl/rx_word_aligner_rotator.sv
// rx_word_rotator: picks the 8-bit window starting at bit 'slip' out of
// {current word, previous word}. Purely combinational so the TX-side test
// path can reuse it.
module rx_word_rotator
  import rx_align_pkg::*;
(
  input  logic [CAT_W-1:0]  cat,
  input  logic [SLIP_W-1:0] slip,
  output logic [WORD_W-1:0] aligned
);

  // Window select; slip = 0 returns the previous word untouched.
  always_comb begin
    aligned = cat[slip +: WORD_W];
  end

endmodule

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: hunts the 8 word-boundary rotations of the deserialised
// lane for a repeated sync word, locks after LOCK_CNT consecutive hits at one
// rotation, then forwards rotated data.
// Optional search timeout: define RX_WORD_ALIGN_TIMEOUT_EN.
module rx_word_aligner
  import rx_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int unsigned       LOCK_CNT    = 4,
  parameter int unsigned       TIMEOUT_CYC = 1024
)
(
  input  logic               clk_i,
  input  logic               rst_i,
  rx_word_aligner_if.slave   bus
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

  state_t            state;
  logic [WORD_W-1:0] prev_q;
  logic [SLIP_W-1:0] slip_q;
  logic [3:0]        cnt_q;
  logic              lock_q;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;

  logic [CAT_W-1:0]  cat;
  logic [WORD_W-1:0] aligned;
  logic              match;
  logic              lock_hit;

`ifdef RX_WORD_ALIGN_TIMEOUT_EN
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_q;
  logic            err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign cat = {bus.data_i, prev_q};

  rx_word_rotator u_rotator (
    .cat     (cat),
    .slip    (slip_q),
    .aligned (aligned)
  );

  // Sync comparison and whether this match completes the lock run.
  always_comb begin
    match    = (aligned == SYNC_WORD);
    lock_hit = 1'b0;
    if (match) begin
      if (state == ST_SEARCH) lock_hit = (LOCK_CNT == 1);
      else                    lock_hit = (cnt_q == LOCK_LAST);
    end
  end

  // Alignment FSM with registered data/status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      prev_q  <= '0;
      slip_q  <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!bus.algn_done_i) begin
        // Losing bit alignment drops everything back to idle.
        state  <= ST_IDLE;
        slip_q <= '0;
        cnt_q  <= '0;
        lock_q <= 1'b0;
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
        err_q  <= 1'b0;
`endif
      end else if (bus.restart_i) begin
        // Restart word is discarded: it neither primes nor is forwarded.
        state  <= ST_PRIME;
        slip_q <= '0;
        cnt_q  <= '0;
        lock_q <= 1'b0;
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
        to_q   <= '0;
        err_q  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_PRIME;
            slip_q <= '0;
            cnt_q  <= '0;
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
            to_q   <= '0;
`endif
          end

          ST_PRIME: begin
            if (bus.valid_i) begin
              prev_q  <= bus.data_i;
              data_q  <= aligned;
              valid_q <= 1'b1;
              state   <= ST_SEARCH;
            end
          end

          // SEARCH and VERIFY share one body: in SEARCH cnt_q is already 0,
          // so a mismatch behaves identically in both.
          ST_SEARCH, ST_VERIFY: begin
            if (bus.valid_i) begin
              prev_q  <= bus.data_i;
              data_q  <= aligned;
              valid_q <= 1'b1;
              if (match) begin
                cnt_q <= (state == ST_SEARCH) ? 4'd1 : cnt_q + 4'd1;
                if (lock_hit) begin
                  state  <= ST_LOCKED;
                  lock_q <= 1'b1;
                end else begin
                  state <= ST_VERIFY;
                end
              end else begin
                cnt_q  <= '0;
                slip_q <= next_slip(slip_q);
                state  <= ST_SEARCH;
              end
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
              to_q <= to_q + TO_W'(1);
              if (!lock_hit && (to_q == TO_LAST)) begin
                state <= ST_FAIL;
                err_q <= 1'b1;
              end
`endif
            end
          end

          ST_LOCKED: begin
            if (bus.valid_i) begin
              prev_q  <= bus.data_i;
              data_q  <= aligned;
              valid_q <= 1'b1;
            end
          end

`ifdef RX_WORD_ALIGN_TIMEOUT_EN
          ST_FAIL: begin
            if (bus.valid_i) begin
              prev_q <= bus.data_i;
            end
          end
`endif

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.lock_o  = lock_q;
  assign bus.slip_o  = slip_q;
`ifdef RX_WORD_ALIGN_TIMEOUT_EN
  assign bus.err_o   = err_q;
`else
  assign bus.err_o   = 1'b0;
`endif

endmodule
